// File: rtl/pc_unit_if.sv
// Fetch-stage program-counter bundle: control inputs from the pipeline and PC/RAS status back.
// The master drives redirect/trap/return requests; the slave is the PC unit itself.
interface pc_unit_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             boot_valid;
    logic [XLEN-1:0]  pc_start;
    logic             stall;
    logic             trap_valid;
    logic [XLEN-1:0]  trap_vec;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_target;
    logic             redirect_is_call;
    logic             ret_valid;
    logic [XLEN-1:0]  ret_addr_in;

    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  pc_plus_inc;
    logic [XLEN-1:0]  pc_next;
    logic             misalign;
    logic [CNT_W-1:0] ras_count;
    logic             ras_miss;

    modport master (
        output boot_valid, pc_start, stall, trap_valid, trap_vec,
               redirect_valid, redirect_target, redirect_is_call,
               ret_valid, ret_addr_in,
        input  pc_out, pc_plus_inc, pc_next, misalign, ras_count, ras_miss
    );

    modport slave (
        input  boot_valid, pc_start, stall, trap_valid, trap_vec,
               redirect_valid, redirect_target, redirect_is_call,
               ret_valid, ret_addr_in,
        output pc_out, pc_plus_inc, pc_next, misalign, ras_count, ras_miss
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC selection with an optional circular return-address stack.
// Define PC_RAS_EN to build the RAS; otherwise every return uses the register-file address.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter int              INC       = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);
    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pcPlusInc;
    logic            rasMiss_q;
    logic            rasMiss_d;
    logic            retWin;
    logic            doPush;
    logic            doPop;
    logic            rasHit;
    logic [XLEN-1:0] rasTop;

    assign pcPlusInc = pc_q + INC_V;

    // Boot and trap sit above everything, so a push or pop only happens when its source actually wins.
    always_comb begin
        pc_d   = pcPlusInc;
        doPush = 1'b0;
        doPop  = 1'b0;
        retWin = 1'b0;
        if (bus.boot_valid) begin
            pc_d = bus.pc_start;
        end else if (bus.trap_valid) begin
            pc_d = bus.trap_vec;
        end else if (bus.redirect_valid) begin
            pc_d   = bus.redirect_target;
            doPush = bus.redirect_is_call;
        end else if (bus.ret_valid) begin
            retWin = 1'b1;
            if (rasHit) begin
                pc_d  = rasTop;
                doPop = 1'b1;
            end else begin
                pc_d = bus.ret_addr_in;
            end
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    assign rasMiss_d = retWin & ~rasHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VEC;
            rasMiss_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rasMiss_q <= rasMiss_d;
        end
    end

`ifdef PC_RAS_EN
    logic [XLEN-1:0]  rasMem [RAS_DEPTH];
    logic [PTR_W-1:0] rasPtr_q;
    logic [PTR_W-1:0] rasPtr_d;
    logic [CNT_W-1:0] rasCount_q;
    logic [CNT_W-1:0] rasCount_d;

    // rasPtr_q is the next free slot; wrapping it on overflow silently drops the oldest entry.
    assign rasHit = (rasCount_q != '0);
    assign rasTop = rasMem[rasPtr_q - PTR_W'(1)];

    always_comb begin
        rasPtr_d   = rasPtr_q;
        rasCount_d = rasCount_q;
        if (bus.boot_valid) begin
            rasCount_d = '0;
        end else if (doPush) begin
            rasPtr_d = rasPtr_q + PTR_W'(1);
            if (rasCount_q != CNT_W'(RAS_DEPTH)) begin
                rasCount_d = rasCount_q + CNT_W'(1);
            end
        end else if (doPop) begin
            rasPtr_d   = rasPtr_q - PTR_W'(1);
            rasCount_d = rasCount_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rasPtr_q   <= '0;
            rasCount_q <= '0;
        end else begin
            rasPtr_q   <= rasPtr_d;
            rasCount_q <= rasCount_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            rasMem[rasPtr_q] <= pcPlusInc;
        end
    end

    assign bus.ras_count = rasCount_q;
`else
    logic unused_ras;

    assign rasHit        = 1'b0;
    assign rasTop        = '0;
    assign bus.ras_count = '0;
    assign unused_ras    = doPush | doPop;
`endif

    assign bus.pc_out      = pc_q;
    assign bus.pc_plus_inc = pcPlusInc;
    assign bus.pc_next     = pc_d;
    assign bus.misalign    = |(pc_d & ALIGN_MASK);
    assign bus.ras_miss    = rasMiss_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed vectors queue expected results, a monitor compares them.
// Expectations follow whichever RAS build (PC_RAS_EN) is compiled.
module tb_pc_unit;
    localparam int XLEN = 32;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    typedef struct {
        logic            boot;
        logic [XLEN-1:0] start;
        logic            stall;
        logic            trap;
        logic [XLEN-1:0] tvec;
        logic            redir;
        logic [XLEN-1:0] target;
        logic            call;
        logic            ret;
        logic [XLEN-1:0] raddr;
    } vec_t;

    typedef struct {
        string           name;
        logic [XLEN-1:0] pc;
        logic            mis;
        logic [31:0]     cnt;
        logic            miss;
    } exp_t;

    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;
    int   pending;
    exp_t sbQueue[$];

    pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .XLEN     (XLEN),
        .INC      (4),
        .RESET_VEC(32'h0000_0100),
        .RAS_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t nop();
        vec_t v;
        v = '{boot: 1'b0, start: '0, stall: 1'b0, trap: 1'b0, tvec: '0, redir: 1'b0,
              target: '0, call: 1'b0, ret: 1'b0, raddr: '0};
        return v;
    endfunction

    function automatic vec_t vBoot(input logic [XLEN-1:0] a);
        vec_t v = nop();
        v.boot  = 1'b1;
        v.start = a;
        return v;
    endfunction

    function automatic vec_t vJump(input logic [XLEN-1:0] t, input logic isCall);
        vec_t v = nop();
        v.redir  = 1'b1;
        v.target = t;
        v.call   = isCall;
        return v;
    endfunction

    function automatic vec_t vRet(input logic [XLEN-1:0] a);
        vec_t v = nop();
        v.ret   = 1'b1;
        v.raddr = a;
        return v;
    endfunction

    // Drives one vector on the falling edge; pc_next must already equal the PC expected after the next rise.
    task automatic applyStimulus(input string name, input vec_t v, input logic [XLEN-1:0] expPc,
                                 input int expCnt, input logic expMiss);
        exp_t e;
        @(negedge clk);
        bus.boot_valid       = v.boot;
        bus.pc_start         = v.start;
        bus.stall            = v.stall;
        bus.trap_valid       = v.trap;
        bus.trap_vec         = v.tvec;
        bus.redirect_valid   = v.redir;
        bus.redirect_target  = v.target;
        bus.redirect_is_call = v.call;
        bus.ret_valid        = v.ret;
        bus.ret_addr_in      = v.raddr;
        e.name = name;
        e.pc   = expPc;
        e.mis  = (expPc[1:0] != 2'b00);
        e.cnt  = 32'(expCnt);
        e.miss = expMiss;
        sbQueue.push_back(e);
        pending++;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 20 && pending != 0; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("scoreboard drained", 32'(pending), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                checkOutput({e.name, " pc_next"}, bus.pc_next, e.pc);
                checkOutput({e.name, " misalign"}, 32'(bus.misalign), 32'(e.mis));
                @(posedge clk);
                #1;
                checkOutput({e.name, " pc_out"}, bus.pc_out, e.pc);
                checkOutput({e.name, " ras_count"}, 32'(bus.ras_count), e.cnt);
                checkOutput({e.name, " ras_miss"}, 32'(bus.ras_miss), 32'(e.miss));
                pending--;
            end
        end
    end

    initial begin : stimulus
        vec_t v;
        testCount = 0;
        failCount = 0;
        pending   = 0;
        rst_n     = 1'b0;
        bus.boot_valid = 1'b0; bus.pc_start = '0; bus.stall = 1'b0;
        bus.trap_valid = 1'b0; bus.trap_vec = '0; bus.redirect_valid = 1'b0;
        bus.redirect_target = '0; bus.redirect_is_call = 1'b0;
        bus.ret_valid = 1'b0; bus.ret_addr_in = '0;

        #12;
        checkOutput("reset pc_out", bus.pc_out, 32'h100);
        checkOutput("reset ras_count", 32'(bus.ras_count), 32'd0);
        checkOutput("reset ras_miss", 32'(bus.ras_miss), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("inc0", nop(), 32'h104, 0, 1'b0);
        applyStimulus("inc1", nop(), 32'h108, 0, 1'b0);
        applyStimulus("inc2", nop(), 32'h10C, 0, 1'b0);
        waitIdle();

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async reset pc_out", bus.pc_out, 32'h100);
        checkOutput("async reset ras_count", 32'(bus.ras_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus("inc3", nop(), 32'h104, 0, 1'b0);
        applyStimulus("inc4", nop(), 32'h108, 0, 1'b0);
        v = nop(); v.stall = 1'b1;
        applyStimulus("stall0", v, 32'h108, 0, 1'b0);
        applyStimulus("stall1", v, 32'h108, 0, 1'b0);
        v = vJump(32'h2000, 1'b0); v.stall = 1'b1;
        applyStimulus("stall redirect", v, 32'h2000, 0, 1'b0);

        // Priority: trap beats redirect and return; boot beats all and empties the RAS.
        applyStimulus("prio call", vJump(32'h3000, 1'b1), 32'h3000, RAS_EN ? 1 : 0, 1'b0);
        v = vJump(32'h2000, 1'b1); v.trap = 1'b1; v.tvec = 32'h80; v.ret = 1'b1; v.raddr = 32'hDEAD;
        applyStimulus("prio trap", v, 32'h80, RAS_EN ? 1 : 0, 1'b0);
        v.boot = 1'b1; v.start = 32'h400;
        applyStimulus("prio boot", v, 32'h400, 0, 1'b0);

        applyStimulus("boot 1000", vBoot(32'h1000), 32'h1000, 0, 1'b0);
        applyStimulus("call 3000", vJump(32'h3000, 1'b1), 32'h3000, RAS_EN ? 1 : 0, 1'b0);
        applyStimulus("ret hit", vRet(32'hDEAD), RAS_EN ? 32'h1004 : 32'hDEAD, 0, !RAS_EN);
        applyStimulus("ret miss", vRet(32'hDEAD), 32'hDEAD, 0, 1'b1);
        applyStimulus("miss clears", nop(), 32'hDEB1, 0, 1'b0);

        applyStimulus("boot 10", vBoot(32'h10), 32'h10, 0, 1'b0);
        applyStimulus("call1", vJump(32'h20, 1'b1), 32'h20, RAS_EN ? 1 : 0, 1'b0);
        applyStimulus("call2", vJump(32'h30, 1'b1), 32'h30, RAS_EN ? 2 : 0, 1'b0);
        applyStimulus("call3", vJump(32'h40, 1'b1), 32'h40, RAS_EN ? 3 : 0, 1'b0);
        applyStimulus("call4", vJump(32'h50, 1'b1), 32'h50, RAS_EN ? 4 : 0, 1'b0);
        applyStimulus("call5 overflow", vJump(32'h60, 1'b1), 32'h60, RAS_EN ? 4 : 0, 1'b0);
        applyStimulus("ovf ret1", vRet(32'hBEEC), RAS_EN ? 32'h54 : 32'hBEEC, RAS_EN ? 3 : 0, !RAS_EN);
        applyStimulus("ovf ret2", vRet(32'hBEEC), RAS_EN ? 32'h44 : 32'hBEEC, RAS_EN ? 2 : 0, !RAS_EN);
        applyStimulus("ovf ret3", vRet(32'hBEEC), RAS_EN ? 32'h34 : 32'hBEEC, RAS_EN ? 1 : 0, !RAS_EN);
        applyStimulus("ovf ret4", vRet(32'hBEEC), RAS_EN ? 32'h24 : 32'hBEEC, 0, !RAS_EN);
        applyStimulus("ovf ret5", vRet(32'hBEEC), 32'hBEEC, 0, 1'b1);

        applyStimulus("boot top", vBoot(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 1'b0);
        applyStimulus("wrap", nop(), 32'h0, 0, 1'b0);
        applyStimulus("misaligned jump", vJump(32'h1002, 1'b0), 32'h1002, 0, 1'b0);
        applyStimulus("after misalign", nop(), 32'h1006, 0, 1'b0);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
